// File: rtl/pic_host_sequencer.sv
// -----------------------------------------------------------------------------
// pic_host_sequencer
//
// Host-side sequencer for an 8259-style interrupt controller. It programs the
// PIC with its initialization command words, then services interrupts by
// running the two-pulse INTA handshake and capturing the vector that the PIC
// presents during the second pulse.
//
// Parameters
//   PULSE_W   low width, in clk cycles, of every WR and INTA strobe (1..15)
//   GAP_W     high cycles between INTA1 and INTA2 (1..15)
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   icw_start               one-cycle request to program the PIC (IDLE only)
//   icw1..icw4              init words, sampled on the accepted icw_start cycle
//   int_en                  enables interrupt acknowledge
//   INT                     asynchronous interrupt request from the PIC
//   DATA_IN                 PIC data bus, sampled on the last INTA2 cycle
//   DATA_OUT, A0            write data and address to the PIC
//   CS, WR, RD, INTA        active-low PIC strobes (RD is reserved, held high)
//   vector, vector_valid    last captured vector; one-cycle update pulse
//   busy, init_done         sequence in progress; PIC programmed
// -----------------------------------------------------------------------------
module pic_host_sequencer #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       icw_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       int_en,
  input  logic       INT,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       INTA,
  output logic       A0,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       busy,
  output logic       init_done
);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, ACK1, ACK_GAP, ACK2, DONE
  } state_e;

  // Counters hold "cycles remaining minus one", so a phase ends when they hit 0.
  localparam logic [3:0] PULSE_RELOAD = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_RELOAD   = 4'(GAP_W - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;     // which init word is on the bus
  logic [3:0][7:0] icw_q, icw_d;     // icw_q[0] = ICW1 ... icw_q[3] = ICW4
  logic [1:0]      cool_q, cool_d;   // post-acknowledge cooldown cycles left
  logic            init_done_q, init_done_d;
  logic [7:0]      vector_q, vector_d;
  logic            int_m_q, int_s_q; // INT synchronizer, int_s_q is the output

  logic            has_next;
  logic [1:0]      next_idx;
  logic            ack_ok;
  logic            in_write;

  // Next word in the write list: ICW3 only in cascade mode (ICW1[1]=0),
  // ICW4 only when ICW1[0] requests it.
  always_comb begin
    has_next = 1'b1;
    next_idx = idx_q;
    unique case (idx_q)
      2'd0: next_idx = 2'd1;
      2'd1: begin
        if (!icw_q[0][1])     next_idx = 2'd2;
        else if (icw_q[0][0]) next_idx = 2'd3;
        else                  has_next = 1'b0;
      end
      2'd2: begin
        if (icw_q[0][0]) next_idx = 2'd3;
        else             has_next = 1'b0;
      end
      default: has_next = 1'b0;
    endcase
  end

  assign ack_ok = int_s_q && int_en && init_done_q && (cool_q == 2'd0);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    icw_d       = icw_q;
    cool_d      = cool_q;
    init_done_d = init_done_q;
    vector_d    = vector_q;

    unique case (state_q)
      IDLE: begin
        if (cool_q != 2'd0) cool_d = cool_q - 2'd1;
        // Programming wins over a simultaneous acknowledge; the ack condition
        // is simply evaluated again once the writes are finished.
        if (icw_start) begin
          icw_d       = {icw4, icw3, icw2, icw1};
          idx_d       = 2'd0;
          init_done_d = 1'b0;
          cool_d      = 2'd0;
          cnt_d       = 4'd0;
          state_d     = W_SETUP;
        end else if (ack_ok) begin
          cnt_d   = PULSE_RELOAD;
          state_d = ACK1;
        end
      end
      W_SETUP: begin
        cnt_d   = PULSE_RELOAD;
        state_d = W_STROBE;
      end
      W_STROBE: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = 4'd0;
          state_d = W_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      W_HOLD: begin
        cnt_d = 4'd0;
        if (has_next) begin
          idx_d   = next_idx;
          state_d = W_SETUP;
        end else begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      ACK1: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = GAP_RELOAD;
          state_d = ACK_GAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK_GAP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = PULSE_RELOAD;
          state_d = ACK2;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK2: begin
        if (cnt_q == 4'd0) begin
          vector_d = DATA_IN;  // PIC drives the vector during INTA2
          cnt_d    = 4'd0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        cnt_d   = 4'd0;
        cool_d  = 2'd2;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= 2'd0;
      // NOTE: the init-word store is small, so it is reset with everything
      // else; DATA_OUT is then well defined from the first cycle.
      icw_q       <= '0;
      cool_q      <= 2'd0;
      init_done_q <= 1'b0;
      vector_q    <= 8'h00;
      int_m_q     <= 1'b0;
      int_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      icw_q       <= icw_d;
      cool_q      <= cool_d;
      init_done_q <= init_done_d;
      vector_q    <= vector_d;
      int_m_q     <= INT;
      int_s_q     <= int_m_q;
    end
  end

  // Strobes decode straight from the state register, so reset releases them
  // asynchronously and WR/INTA can never be low together.
  assign in_write     = (state_q == W_SETUP) || (state_q == W_STROBE) || (state_q == W_HOLD);
  assign CS           = ~in_write;
  assign WR           = ~(state_q == W_STROBE);
  assign RD           = 1'b1;
  assign INTA         = ~((state_q == ACK1) || (state_q == ACK2));
  assign A0           = in_write && (idx_q != 2'd0);
  assign DATA_OUT     = in_write ? icw_q[idx_q] : 8'h00;
  assign vector       = vector_q;
  assign vector_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign init_done    = init_done_q;

endmodule

// File: doc/pic_host_sequencer.md
PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

Interface
REQ-001 SHALL have parameter PULSE_W, default 2: low width, in clk cycles, of every WR and INTA strobe (legal 1..15).
REQ-002 SHALL have parameter GAP_W, default 1: high cycles between INTA1 and INTA2 (legal 1..15).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 icw_start  input  1  one-cycle request to program the PIC.
REQ-006 icw1, icw2, icw3, icw4  input  8 each  init words; sampled on the icw_start cycle.
REQ-007 int_en  input  1  enables interrupt acknowledge.
REQ-008 INT  input  1  interrupt request from the PIC; asynchronous.
REQ-009 DATA_IN  input  8  PIC data bus, read during INTA2.
REQ-010 DATA_OUT  output  8  data driven to the PIC during writes.
REQ-011 CS, WR, RD, INTA  output  1 each  active-low PIC strobes.
REQ-012 A0  output  1  PIC address line.
REQ-013 vector  output  8  last captured interrupt vector.
REQ-014 vector_valid  output  1  one-cycle pulse when vector updates.
REQ-015 busy, init_done  output  1 each  sequence in progress; PIC programmed.

Function
REQ-016 SHALL implement states IDLE, W_SETUP, W_STROBE, W_HOLD, ACK1, ACK_GAP, ACK2, DONE.
REQ-017 SHALL synchronize INT through two flops; int_s is the second flop.
REQ-018 The write list SHALL be built as follows:
- ICW1 with A0=0.
- ICW2 with A0=1.
- ICW3 with A0=1, only if icw1[1]=0.
- ICW4 with A0=1, only if icw1[0]=1.
REQ-019 Each write SHALL run in this order:
- W_SETUP: 1 cycle; CS=0, A0 and DATA_OUT valid.
- W_STROBE: PULSE_W cycles; WR=0.
- W_HOLD: 1 cycle; WR=1, CS=0, data held.
- Next listed word goes to W_SETUP; otherwise IDLE.
REQ-020 icw_start in IDLE SHALL clear init_done immediately, then set init_done in the cycle that leaves the final W_HOLD.
REQ-021 In IDLE, int_s=1 with int_en=1 and init_done=1 SHALL start the acknowledge sequence:
- ACK1: PULSE_W cycles, INTA=0.
- ACK_GAP: GAP_W cycles, INTA=1.
- ACK2: PULSE_W cycles, INTA=0.
- DONE: 1 cycle.
REQ-022 SHALL load vector from DATA_IN on the last ACK2 cycle and assert vector_valid during DONE.
REQ-023 DONE SHALL be followed by 2 cooldown cycles in IDLE, during which int_s is ignored.
REQ-024 If icw_start and the ack condition are both true in IDLE, icw_start SHALL win and the ack SHALL be re-evaluated after init.
REQ-025 icw_start outside IDLE SHALL be ignored with no latching; INT during writes SHALL wait for IDLE.
REQ-026 int_en or INT falling during ACK1..DONE SHALL NOT abort the sequence.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 RD SHALL remain 1 at all times; the port is reserved for OCW3 reads.
REQ-029 Only one of WR or INTA SHALL be low in any cycle.
REQ-030 Strobe counters SHALL be 4 bits wide and reload on every state entry.

Reset
REQ-031 reset_n=0 SHALL immediately force the following, mid-strobe included:
- state=IDLE
- CS=WR=RD=INTA=1
- A0=0
- DATA_OUT=0x00
- vector=0x00
- vector_valid=0, busy=0, init_done=0
- synchronizers cleared, cooldown cleared

Verification
REQ-032 Full init: icw_start, icw1=0x11, icw2=0x20, icw3=0x04, icw4=0x01 -> four writes 0x11/A0=0, 0x20/A0=1, 0x04/A0=1, 0x01/A0=1; each WR low for 2 cycles; init_done=1 after 16 cycles.
REQ-033 Single mode: icw1=0x13 -> writes 0x13, 0x20, 0x01 only; ICW3 is skipped.
REQ-034 Acknowledge: init_done=1, int_en=1, INT rises, DATA_IN=0x23 -> INTA low 2 cycles, high 1, low 2; vector=0x23; vector_valid one cycle; no second ack while INT stays high for the 2 cooldown cycles.
REQ-035 Collision: INT high in the same cycle as icw_start -> init runs first, then the ack starts from IDLE.
REQ-036 Blocking: int_en=0 or init_done=0 with INT high -> INTA stays 1 indefinitely.
REQ-037 Reset during the ACK2 low phase -> INTA=1 asynchronously; vector stays 0x00; no vector_valid pulse.
